// File: rtl/special_case_encoder.sv
// FPHUB adder output stage: maps a special-case code to its canonical HUB word
// (or passes the normal result through) and buffers it in a 2-entry FIFO.
// Optional illegal-code flagging is enabled by defining SPECIAL_ENC_CHECK_EN.
module special_case_encoder #(
  parameter int M            = 23,
  parameter int E            = 8,
  parameter int special_case = 7,
  localparam int CW          = $clog2(special_case),
  localparam int W           = E + M + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_code,
  input  logic [W-1:0]  in_result,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          out_special,
  output logic          err,
  input  logic          err_clr
);

  localparam logic [CW-1:0] C_PINF  = CW'(1);
  localparam logic [CW-1:0] C_NINF  = CW'(2);
  localparam logic [CW-1:0] C_PZERO = CW'(3);
  localparam logic [CW-1:0] C_NZERO = CW'(4);
  localparam logic [CW-1:0] C_PONE  = CW'(5);
  localparam logic [CW-1:0] C_NONE  = CW'(6);

  typedef struct packed {
    logic         special;
    logic [W-1:0] data;
  } entry_t;

  logic [W-1:0] enc_data;
  logic         enc_special;

  // Code 0 and any unlisted code fall through to the normal-path result.
  always_comb begin
    enc_data    = in_result;
    enc_special = 1'b0;
    case (in_code)
      C_PINF:  begin enc_data = {1'b0, {(W-1){1'b1}}};               enc_special = 1'b1; end
      C_NINF:  begin enc_data = {1'b1, {(W-1){1'b1}}};               enc_special = 1'b1; end
      C_PZERO: begin enc_data = '0;                                  enc_special = 1'b1; end
      C_NZERO: begin enc_data = {1'b1, {(W-1){1'b0}}};               enc_special = 1'b1; end
      C_PONE:  begin enc_data = {1'b0, 1'b1, {(W-2){1'b0}}};         enc_special = 1'b1; end
      C_NONE:  begin enc_data = {1'b1, 1'b1, {(W-2){1'b0}}};         enc_special = 1'b1; end
      default: ;
    endcase
  end

  entry_t [1:0] mem_q, mem_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         accept, pop;

  // Ready comes from the registered count only, so out_ready never reaches in_ready.
  assign in_ready    = (cnt_q != 2'd2);
  assign out_valid   = (cnt_q != 2'd0);
  assign accept      = in_valid && in_ready;
  assign pop         = out_valid && out_ready;
  assign out_data    = mem_q[rd_ptr_q].data;
  assign out_special = mem_q[rd_ptr_q].special;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q ^ accept;
    rd_ptr_d = rd_ptr_q ^ pop;
    cnt_d    = cnt_q + 2'(accept) - 2'(pop);
    if (accept) begin
      mem_d[wr_ptr_q].special = enc_special;
      mem_d[wr_ptr_q].data    = enc_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef SPECIAL_ENC_CHECK_EN
  logic err_q, err_d, illegal;

  assign illegal = (32'(in_code) >= 32'(special_case));

  // Set has priority over a same-cycle clear.
  always_comb begin
    err_d = err_q;
    if (err_clr)            err_d = 1'b0;
    if (accept && illegal)  err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_special_case_encoder.sv
// Randomized bench for special_case_encoder with a queue-based reference model,
// plus directed literal checks for the canonical encodings and buffer corners.
module tb_special_case_encoder;
  localparam int M  = 23;
  localparam int E  = 8;
  localparam int SC = 7;
  localparam int CW = $clog2(SC);
  localparam int W  = E + M + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_code;
  logic [W-1:0]  in_result;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_special;
  logic          err;
  logic          err_clr;

  special_case_encoder #(.M(M), .E(E), .special_case(SC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .in_result(in_result), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_special(out_special),
    .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: build the word from sign/exponent/mantissa fields by meaning.
  function automatic logic [W:0] model_enc(input logic [CW-1:0] c, input logic [W-1:0] r);
    logic s;
    logic [E-1:0] ex;
    logic [M-1:0] mn;
    int ci;
    ci = int'(c);
    s  = (ci == 2) || (ci == 4) || (ci == 6);
    if (ci == 1 || ci == 2) begin ex = '1; mn = '1; end
    else if (ci == 3 || ci == 4) begin ex = '0; mn = '0; end
    else if (ci == 5 || ci == 6) begin ex = '0; ex[E-1] = 1'b1; mn = '0; end
    else return {1'b0, r};
    return {1'b1, s, ex, mn};
  endfunction

  logic [W:0] mq[$];
  bit         merr;
  bit         m_acc, m_pop;
  logic [W:0] m_ent;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      merr = 0;
    end else begin
      m_acc = in_valid && (mq.size() < 2);
      m_pop = (mq.size() != 0) && out_ready;
      m_ent = model_enc(in_code, in_result);
      if (m_pop) void'(mq.pop_front());
      if (m_acc) mq.push_back(m_ent);
`ifdef SPECIAL_ENC_CHECK_EN
      if (err_clr) merr = 0;
      if (m_acc && int'(in_code) >= SC) merr = 1;
`endif
    end
  end

  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
      chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
      chk("err", 64'(err), 64'(merr));
      if (mq.size() != 0) begin
        chk("out_data", 64'(out_data), 64'(mq[0][W-1:0]));
        chk("out_special", 64'(out_special), 64'(mq[0][W]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int code, input logic [W-1:0] res);
    in_valid  = v;
    in_code   = CW'(code);
    in_result = res;
  endtask

  logic [W-1:0] lit [6];

  initial begin
    lit[0] = 32'h7FFFFFFF; lit[1] = 32'hFFFFFFFF; lit[2] = 32'h00000000;
    lit[3] = 32'h80000000; lit[4] = 32'h40000000; lit[5] = 32'hC0000000;

    rst_n = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
    drive(1, 1, 32'h0);
    repeat (3) begin
      step();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
    end
    #2 rst_n = 1'b1;
    cmp_en = 1;
    #1 chk("no_pre_edge_entry", 64'(out_valid), 64'd0);

    // Codes 1..6 back-to-back; each word shows one edge after its accept.
    @(posedge clk); #1;
    for (int i = 1; i <= 6; i++) begin
      drive(1, i, 32'h12345678);
      step();
      chk($sformatf("code%0d_data", i), 64'(out_data), 64'(lit[i-1]));
      chk($sformatf("code%0d_special", i), 64'(out_special), 64'd1);
    end
    drive(1, 0, 32'h3F8CCCCD); step();
    chk("pass_data", 64'(out_data), 64'h3F8CCCCD);
    chk("pass_special", 64'(out_special), 64'd0);
    drive(1, 3, 32'h12345678); step();
    chk("pzero_ignores_result", 64'(out_data), 64'h0);
    drive(0, 0, 32'h0); step();

    // Back-pressure: third word must wait until the buffer drains.
    out_ready = 1'b0;
    drive(1, 0, 32'hAAAA0001); step();
    drive(1, 0, 32'hAAAA0002); step();
    chk("full_in_ready", 64'(in_ready), 64'd0);
    drive(1, 0, 32'hAAAA0003); step(); step();
    chk("stall_hold_data", 64'(out_data), 64'hAAAA0001);
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1; step();
    chk("drain_1", 64'(out_data), 64'hAAAA0002);
    step();
    chk("drain_2", 64'(out_data), 64'hAAAA0003);
    drive(0, 0, 32'h0); step();
    chk("drained", 64'(out_valid), 64'd0);

`ifdef SPECIAL_ENC_CHECK_EN
    drive(1, 7, 32'h11111111); step();
    chk("ill_data", 64'(out_data), 64'h11111111);
    chk("ill_special", 64'(out_special), 64'd0);
    chk("ill_err_set", 64'(err), 64'd1);
    err_clr = 1'b1; step();
    chk("set_beats_clr", 64'(err), 64'd1);
    drive(0, 0, 32'h0); step();
    chk("err_cleared", 64'(err), 64'd0);
    err_clr = 1'b0;
`else
    drive(1, 7, 32'h11111111); step();
    chk("ill_data", 64'(out_data), 64'h11111111);
    chk("ill_special", 64'(out_special), 64'd0);
    chk("ill_no_err", 64'(err), 64'd0);
    drive(0, 0, 32'h0); step();
`endif

    // Reset while full discards both entries immediately.
    out_ready = 1'b0;
    drive(1, 1, 32'h0); step();
    drive(1, 2, 32'h0); step();
    chk("pre_rst_full", 64'(in_ready), 64'd0);
    drive(0, 0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    step();
    rst_n = 1'b1; out_ready = 1'b1;
    drive(1, 5, 32'h0); step();
    chk("post_rst_word", 64'(out_data), 64'h40000000);
    drive(0, 0, 32'h0); step();
    chk("no_stale", 64'(out_valid), 64'd0);

    // Randomized traffic against the queue model.
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)), W'($urandom));
      out_ready = $urandom_range(0, 2) != 0;
      err_clr   = $urandom_range(0, 9) == 0;
      step();
    end
    drive(0, 0, 32'h0); err_clr = 1'b0; out_ready = 1'b1;
    step(); step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/special_case_encoder.md
# special_case_encoder

Inverse of the operand special-case classifier in the FPHUB adder datapath. It takes a special-case code plus the normal-path adder result. It emits the final HUB-format word: either the canonical encoding for the code, or the normal result passed through unchanged. The block sits at the adder output stage. It carries a 2-entry valid/ready output buffer so downstream back-pressure does not stall the adder combinationally.

## Interface
- M, 23, mantissa width
- E, 8, exponent width
- special_case, 7, number of codes including "none"; code width CW = $clog2(special_case)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input word present
- in_ready  out  1  block can accept input this cycle
- in_code  in  CW  special-case code (0 none, 1 +inf, 2 −inf, 3 +0, 4 −0, 5 +1, 6 −1)
- in_result  in  E+M+1  normal-path result, used only when code is 0
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- out_data  out  E+M+1  final HUB word
- out_special  out  1  out_data came from a nonzero code
- err  out  1  sticky illegal-code flag (see Configuration)
- err_clr  in  1  synchronous clear of err

## Operation
- Word layout: sign = bit E+M, exponent = bits E+M−1:M, mantissa = bits M−1:0.
- Encoding per code:
  - 1: {0, all ones}
  - 2: {1, all ones}
  - 3: all zeros
  - 4: {1, zeros}
  - 5: {0, 1, E+M−1 zeros}
  - 6: {1, 1, E+M−1 zeros}
  - 0: in_result verbatim
- out_special = (code ∈ 1..6).
- Encoding is combinational on the input side. The encoded word and out_special are written into the buffer on accept.
- Buffer:
  - 2-entry FIFO with read pointer, write pointer and count (0..2).
  - Accept = in_valid && in_ready.
  - Pop = out_valid && out_ready.
- in_ready = (count < 2). It is derived from registered count only and never depends on out_ready combinationally.
- out_valid = (count != 0). out_data and out_special always show the head entry.
- Simultaneous accept and pop:
  - count 1: count stays 1.
  - count 2: accept is impossible.
  - count 0: the pushed word becomes head next cycle; there is no bypass.
- Pointers are 1 bit each and wrap modulo 2.
- Reset values: count 0, pointers 0, out_valid 0, in_ready 1, out_data 0, out_special 0, err 0.
- Reset asserted mid-transfer discards all buffered entries.

## Timing
- Latency: a word accepted at edge N is visible on out_data after edge N (cycle N+1).
- Throughput: 1 word/cycle sustained while out_ready = 1.
- A stalled head word holds out_data and out_special stable while out_valid = 1 and out_ready = 0.
- err sets on the edge of an accept carrying an illegal code. err_clr clears it on the next edge.
- If set and clear occur in the same cycle, set wins.

## Configuration
- SPECIAL_ENC_CHECK_EN defined:
  - Codes ≥ special_case (e.g. 7) are illegal.
  - The word is encoded as code 0 (in_result passed through) with out_special = 0.
  - err is set on accept.
- SPECIAL_ENC_CHECK_EN undefined:
  - err is tied 0 and err_clr is ignored.
  - Illegal codes still pass in_result through with out_special = 0, with no flagging.

## Test plan
- Reset with in_valid = 1 during reset → out_valid 0, in_ready 1, err 0 throughout. No entry is stored before the first post-reset edge.
- Codes 1..6 back-to-back with out_ready = 1, M = 23, E = 8 → out_data 0x7FFFFFFF, 0xFFFFFFFF, 0x00000000, 0x80000000, 0x40000000, 0xC0000000. Each word appears one cycle after accept and carries out_special = 1.
- Code 0 with in_result = 0x3F8CCCCD → out_data 0x3F8CCCCD, out_special 0. Code 3 with in_result = 0x12345678 → 0x00000000.
- Hold out_ready = 0 and push 3 words → in_ready drops after the 2nd accept and the 3rd is held off. Release out_ready → words emerge in order, one per cycle, with no loss or duplication.
- With SPECIAL_ENC_CHECK_EN, push code 7 with in_result 0x11111111 → out_data 0x11111111, out_special 0, err = 1. Assert err_clr together with a second code-7 accept → err stays 1. Assert err_clr alone → err = 0.
- Assert rst_n low with count = 2 → out_valid 0 and in_ready 1 immediately. After release, the first new word is output and no stale data appears.
